// File: rtl/midi_note_parser_if.sv
// rtl/midi_note_parser_if.sv - byte stream in, note/velocity/gate out for the MIDI parser
interface midi_note_parser_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [6:0] note_idx;
  logic [6:0] velocity;
  logic       gate;
  logic       note_event;

  modport master (
    output byte_in, byte_valid,
    input  note_idx, velocity, gate, note_event
  );

  modport slave (
    input  byte_in, byte_valid,
    output note_idx, velocity, gate, note_event
  );
endinterface

// File: rtl/midi_note_parser.sv
// rtl/midi_note_parser.sv - monophonic MIDI note parser with running status and last-note priority
module midi_note_parser #(
  parameter logic [3:0] CHANNEL = 4'd0,
  parameter bit         OMNI    = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  midi_note_parser_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [6:0] d1_q, d1_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;
  logic       gate_q, gate_d;
  logic       event_q, event_d;

  logic       is_realtime;
  logic       is_system;
  logic       is_status;
  logic       one_byte_msg;
  logic       msg_done;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       chan_ok;
  logic       is_note_on;
  logic       is_note_off;

  assign is_realtime  = (bus.byte_in[7:3] == 5'b11111);
  assign is_system    = (bus.byte_in[7:4] == 4'hF) && !is_realtime;
  assign is_status    = bus.byte_in[7] && (bus.byte_in[7:4] != 4'hF);
  assign one_byte_msg = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
  assign chan_ok      = OMNI || (status_q[3:0] == CHANNEL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      status_q <= 8'h00;
      d1_q     <= 7'd0;
      note_q   <= 7'd0;
      vel_q    <= 7'd0;
      gate_q   <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
      note_q   <= note_d;
      vel_q    <= vel_d;
      gate_q   <= gate_d;
      event_q  <= event_d;
    end
  end

  // Byte classification and message assembly; real-time bytes fall through untouched.
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    msg_done = 1'b0;
    msg_d1   = d1_q;
    msg_d2   = 7'd0;
    if (bus.byte_valid && !is_realtime) begin
      if (is_system) begin
        state_d  = IDLE;
        status_d = 8'h00;
      end else if (is_status) begin
        state_d  = DATA1;
        status_d = bus.byte_in;
      end else begin
        case (state_q)
          DATA1: begin
            d1_d = bus.byte_in[6:0];
            if (one_byte_msg) begin
              msg_done = 1'b1;
              msg_d1   = bus.byte_in[6:0];
            end else begin
              state_d = DATA2;
            end
          end
          DATA2: begin
            msg_done = 1'b1;
            msg_d2   = bus.byte_in[6:0];
            state_d  = DATA1;
          end
          default: ;
        endcase
      end
    end
  end

  // A release only closes the gate when it names the note currently sounding.
  always_comb begin
    note_d      = note_q;
    vel_d       = vel_q;
    gate_d      = gate_q;
    event_d     = 1'b0;
    is_note_on  = (status_q[7:4] == 4'h9) && (msg_d2 != 7'd0);
    is_note_off = (status_q[7:4] == 4'h8) ||
                  ((status_q[7:4] == 4'h9) && (msg_d2 == 7'd0));
    if (msg_done && chan_ok) begin
      if (is_note_on) begin
        note_d  = msg_d1;
        vel_d   = msg_d2;
        gate_d  = 1'b1;
        event_d = 1'b1;
      end else if (is_note_off && gate_q && (msg_d1 == note_q)) begin
        gate_d  = 1'b0;
        event_d = 1'b1;
      end
    end
  end

  assign bus.note_idx   = note_q;
  assign bus.velocity   = vel_q;
  assign bus.gate       = gate_q;
  assign bus.note_event = event_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// tb/tb_midi_note_parser.sv - scoreboard bench for midi_note_parser (omni and channel-filtered instances)
module tb_midi_note_parser;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [14:0] qa[$];
  logic [14:0] qb[$];

  midi_note_parser_if ifa ();
  midi_note_parser_if ifb ();

  midi_note_parser #(.CHANNEL(4'd0), .OMNI(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  midi_note_parser #(.CHANNEL(4'd2), .OMNI(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every note_event pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [14:0] exp_a;
    logic [14:0] exp_b;
    if (rst_n) begin
      if (ifa.note_event === 1'b1) begin
        checks = checks + 1;
        if (qa.size() == 0) begin
          failures = failures + 1;
          $display("FAIL a_unexpected_event note=%0d vel=%0d gate=%0d expected no event",
                   ifa.note_idx, ifa.velocity, ifa.gate);
        end else begin
          exp_a = qa.pop_front();
          if ({ifa.note_idx, ifa.velocity, ifa.gate} !== exp_a) begin
            failures = failures + 1;
            $display("FAIL a_event got note=%0d vel=%0d gate=%0d expected note=%0d vel=%0d gate=%0d",
                     ifa.note_idx, ifa.velocity, ifa.gate, exp_a[14:8], exp_a[7:1], exp_a[0]);
          end
        end
      end
      if (ifb.note_event === 1'b1) begin
        checks = checks + 1;
        if (qb.size() == 0) begin
          failures = failures + 1;
          $display("FAIL b_unexpected_event note=%0d vel=%0d gate=%0d expected no event",
                   ifb.note_idx, ifb.velocity, ifb.gate);
        end else begin
          exp_b = qb.pop_front();
          if ({ifb.note_idx, ifb.velocity, ifb.gate} !== exp_b) begin
            failures = failures + 1;
            $display("FAIL b_event got note=%0d vel=%0d gate=%0d expected note=%0d vel=%0d gate=%0d",
                     ifb.note_idx, ifb.velocity, ifb.gate, exp_b[14:8], exp_b[7:1], exp_b[0]);
          end
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] b);
    if (!sel) begin
      ifa.byte_in    = b;
      ifa.byte_valid = 1'b1;
    end else begin
      ifb.byte_in    = b;
      ifb.byte_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    ifa.byte_valid = 1'b0;
    ifb.byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    idle(2);
    checks = checks + 1;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s_missing_events pending_a=%0d pending_b=%0d expected 0", name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    ifa.byte_in = 8'h90; ifa.byte_valid = 1'b1;
    ifb.byte_in = 8'h92; ifb.byte_valid = 1'b1;
    idle(2);
    ifa.byte_valid = 1'b0;
    ifb.byte_valid = 1'b0;
    checks = checks + 2;
    if ({ifa.note_idx, ifa.velocity, ifa.gate, ifa.note_event} !== 16'h0) begin
      failures = failures + 1;
      $display("FAIL reset_a got note=%0d vel=%0d gate=%0d ev=%0d expected all 0",
               ifa.note_idx, ifa.velocity, ifa.gate, ifa.note_event);
    end
    if ({ifb.note_idx, ifb.velocity, ifb.gate, ifb.note_event} !== 16'h0) begin
      failures = failures + 1;
      $display("FAIL reset_b got note=%0d vel=%0d gate=%0d ev=%0d expected all 0",
               ifb.note_idx, ifb.velocity, ifb.gate, ifb.note_event);
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_note_on;
    send(0, 8'h90);
    send(0, 8'h45);
    qa.push_back({7'd69, 7'd100, 1'b1});
    send(0, 8'h64);
    checks = checks + 1;
    if (ifa.note_event !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL note_on_latency note_event=%0d expected 1 one clock after last byte", ifa.note_event);
    end
    drain("note_on");
  endtask

  task automatic test_running_status;
    send(0, 8'h90); send(0, 8'h3C);
    qa.push_back({7'd60, 7'd64, 1'b1});
    send(0, 8'h40);
    send(0, 8'h40);
    qa.push_back({7'd64, 7'd80, 1'b1});
    send(0, 8'h50);
    send(0, 8'h3C); send(0, 8'h00);
    drain("running_status_a");
    checks = checks + 1;
    if (ifa.gate !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL stale_release_gate got %0d expected 1", ifa.gate);
    end
    send(0, 8'h40);
    qa.push_back({7'd64, 7'd80, 1'b0});
    send(0, 8'h00);
    drain("running_status_b");
    checks = checks + 1;
    if (ifa.note_idx !== 7'd64 || ifa.gate !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL release_hold got note=%0d gate=%0d expected note=64 gate=0", ifa.note_idx, ifa.gate);
    end
  endtask

  task automatic test_realtime;
    send(0, 8'h90); send(0, 8'hF8); send(0, 8'h30); send(0, 8'hFE);
    qa.push_back({7'd48, 7'd127, 1'b1});
    send(0, 8'h7F);
    send(0, 8'hFF); send(0, 8'h30);
    qa.push_back({7'd48, 7'd32, 1'b1});
    send(0, 8'h20);
    send(0, 8'h80); send(0, 8'h30);
    qa.push_back({7'd48, 7'd32, 1'b0});
    send(0, 8'h00);
    send(0, 8'h30); send(0, 8'h00);
    drain("realtime");
  endtask

  task automatic test_channel_filter;
    send(1, 8'h91); send(1, 8'h40); send(1, 8'h40);
    idle(2);
    checks = checks + 1;
    if (ifb.gate !== 1'b0 || ifb.note_idx !== 7'd0) begin
      failures = failures + 1;
      $display("FAIL filter_other_channel got gate=%0d note=%0d expected 0 0", ifb.gate, ifb.note_idx);
    end
    send(1, 8'h92); send(1, 8'h40);
    qb.push_back({7'd64, 7'd64, 1'b1});
    send(1, 8'h40);
    send(1, 8'hC2); send(1, 8'h05); send(1, 8'h40); send(1, 8'h00);
    drain("filter_prog");
    checks = checks + 1;
    if (ifb.gate !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL filter_prog_gate got %0d expected 1", ifb.gate);
    end
    send(1, 8'h82); send(1, 8'h40);
    qb.push_back({7'd64, 7'd64, 1'b0});
    send(1, 8'h10);
    drain("filter_off");
  endtask

  task automatic test_abort_system;
    send(0, 8'h90); send(0, 8'h40); send(0, 8'h91); send(0, 8'h41);
    qa.push_back({7'd65, 7'd34, 1'b1});
    send(0, 8'h22);
    send(0, 8'hF0); send(0, 8'h43); send(0, 8'h10);
    drain("abort_system");
    checks = checks + 1;
    if ({ifa.note_idx, ifa.velocity, ifa.gate} !== {7'd65, 7'd34, 1'b1}) begin
      failures = failures + 1;
      $display("FAIL sysex_ignored got note=%0d vel=%0d gate=%0d expected 65 34 1",
               ifa.note_idx, ifa.velocity, ifa.gate);
    end
  endtask

  task automatic test_back_to_back;
    send(0, 8'h90); send(0, 8'h7F);
    qa.push_back({7'd127, 7'd1, 1'b1});
    send(0, 8'h01);
    send(0, 8'h00);
    qa.push_back({7'd0, 7'd127, 1'b1});
    send(0, 8'h7F);
    send(0, 8'hE0); send(0, 8'h00); send(0, 8'h40);
    send(0, 8'hD0); send(0, 8'h00);
    send(0, 8'h90); send(0, 8'h00);
    qa.push_back({7'd0, 7'd127, 1'b0});
    send(0, 8'h00);
    drain("back_to_back");
  endtask

  task automatic test_mid_reset;
    send(0, 8'h90); send(0, 8'h40);
    rst_n = 1'b0;
    ifa.byte_in = 8'h45;
    ifa.byte_valid = 1'b1;
    idle(1);
    ifa.byte_valid = 1'b0;
    rst_n = 1'b1;
    send(0, 8'h50); send(0, 8'h7F);
    drain("mid_reset");
    checks = checks + 1;
    if ({ifa.note_idx, ifa.velocity, ifa.gate, ifa.note_event} !== 16'h0) begin
      failures = failures + 1;
      $display("FAIL mid_reset_outputs got note=%0d vel=%0d gate=%0d ev=%0d expected all 0",
               ifa.note_idx, ifa.velocity, ifa.gate, ifa.note_event);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    ifa.byte_in = 8'h00; ifa.byte_valid = 1'b0;
    ifb.byte_in = 8'h00; ifb.byte_valid = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_note_on();
    test_running_status();
    test_realtime();
    test_channel_filter();
    test_abort_system();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_note_parser.md
# midi_note_parser

Byte-level MIDI parser that turns a serial MIDI byte stream (from the UART receiver) into a monophonic note index, velocity and gate. It sits directly upstream of the note-to-frequency-step lookup: `note_idx` drives that table's 7-bit index input, and `gate` and `velocity` drive the envelope stage. It handles running status, real-time byte interleaving, velocity-0 note-off and last-note priority.

## Interface
- `CHANNEL`, default 0: MIDI channel (0–15) accepted when `OMNI`=0.
- `OMNI`, default 1: 1 accepts all channels; 0 accepts only `CHANNEL`.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous and active-low.
- `byte_in`  in  8  received MIDI byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle; one-cycle strobe per byte, no backpressure.
- `note_idx`  out  7  current note number (0–127), to the frequency-step table index.
- `velocity`  out  7  velocity of the current note.
- `gate`  out  1  note held.
- `note_event`  out  1  one-cycle pulse on every accepted note-on/off that changes outputs.

## Operation
- A byte is consumed only on cycles with `byte_valid`=1. Other cycles hold all state.
- Real-time bytes (0xF8–0xFF): ignored completely. They do not change state, running status or partial data.
- System common/exclusive (0xF0–0xF7): clear running status and go to IDLE. Following data bytes are discarded until the next channel status byte.
- Channel status byte (0x80–0xEF): latch the status (running status) and go to DATA1. Any partially received message is aborted.
- Message length by status high nibble:
  - 0x8, 0x9, 0xA, 0xB, 0xE: two data bytes.
  - 0xC, 0xD: one data byte.
- States:
  - IDLE: no running status. Data bytes are discarded.
  - DATA1: the next data byte is latched as d1. For 1-byte messages the message completes here and the parser stays in DATA1. Otherwise go to DATA2.
  - DATA2: the next data byte is d2. The message completes and the parser returns to DATA1 (running status).
- On message completion:
  - A message passes the channel filter if `OMNI`=1 or status[3:0]=`CHANNEL`. Otherwise it has no effect.
  - Note-on (0x9n) with d2≠0: `note_idx`←d1, `velocity`←d2, `gate`←1, pulse `note_event`. This retriggers even if the same note is already held.
  - Note-off (0x8n, any d2), or 0x9n with d2=0:
    - If `gate`=1 and d1=`note_idx`: `gate`←0 and pulse `note_event`. `note_idx` and `velocity` hold their values.
    - Otherwise: no effect and no pulse. A released non-current note does not close the gate.
  - All other message types (0xA, 0xB, 0xC, 0xD, 0xE) are consumed silently.
- Data bytes are 7-bit: d1 and d2 are `byte_in[6:0]`.

## Timing
- Reset (`rst_n`=0 at a rising edge): `note_idx`=0, `velocity`=0, `gate`=0, `note_event`=0, state=IDLE, running status cleared. Reset overrides a `byte_valid` in the same cycle and aborts any partial message.
- All outputs are registered. For the final data byte of a message sampled at edge N, `note_idx`, `velocity`, `gate` and `note_event` are valid after edge N. Latency is 1 clock from byte to output.
- `note_event` is high for exactly one cycle. With back-to-back completing messages on consecutive cycles it stays high for both cycles, and the outputs reflect each message in turn.
- Consecutive `byte_valid` cycles are fully supported: throughput is 1 byte/clock.
- No combinational path from `byte_in` to any output.

## Test plan
- Reset, then bytes 0x90 0x45 0x64 → after the third byte: `note_idx`=69, `velocity`=100, `gate`=1, `note_event` pulse of 1 cycle.
- Running status: 0x90 0x3C 0x40 0x40 0x50 → two `note_event` pulses, final `note_idx`=64, `velocity`=80, `gate`=1. Then 0x3C 0x00 → no pulse and `gate` stays 1 (not the current note). Then 0x40 0x00 → `gate`=0 with a pulse, and `note_idx` stays 64.
- Real-time interleave: 0x90 0xF8 0x30 0xFE 0x7F → `note_idx`=48, `velocity`=127, `gate`=1. The real-time bytes do not disturb the parse.
- Channel filter (`OMNI`=0, `CHANNEL`=2): 0x91 0x40 0x40 → no change. 0x92 0x40 0x40 → `gate`=1, `note_idx`=64. Then 0xC2 0x05 0x40 0x00 → no effect (program change consumed, then 0x40 is a new program change). Then 0x82 0x40 0x10 → `gate`=0.
- Abort and system common:
  - 0x90 0x40 0x91 0x41 0x22 → one pulse, `note_idx`=65, `velocity`=34 (the partial message is aborted).
  - Then 0xF0 0x43 0x10 → ignored.
- Mid-message reset: 0x90 0x40, then `rst_n` low for 1 cycle, then 0x50 → all outputs 0 and the data byte is discarded (IDLE).
